dm_subword: RTL and testbench
=============================

DM_SUBWORD -- requirements
Module: dm_subword

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the word-address width; DEPTH = 2**ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter TRACE, default 1; when set to 1, the block prints a simulation-only store trace.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 clr_n  in  1  reset, synchronous, active-low.
REQ-005 req  in  1  access request, sampled each rising edge.
REQ-006 we  in  1  1 = store, 0 = load; qualified by req.
REQ-007 size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 sext  in  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word loads and stores.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 pc  in  32  address of the issuing instruction; used only for the trace.
REQ-012 rdata  out  32  registered, extended load result.
REQ-013 rvalid  out  1  one-cycle pulse marking rdata valid.
REQ-014 addr_err  out  1  one-cycle pulse marking a rejected access.
REQ-015 busy  out  1  1 while the memory is clearing; requests are ignored while busy is 1.

Function
REQ-016 The FSM SHALL have two states: CLEAR and IDLE.
REQ-017 In CLEAR, the block SHALL write zero to word index cnt, then increment cnt, once per cycle.
REQ-018 The FSM SHALL move from CLEAR to IDLE on the edge that clears word DEPTH-1, so a full clear takes exactly DEPTH cycles.
REQ-019 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-020 A request accepted while busy=1 SHALL cause no write, no rvalid and no addr_err pulse.
REQ-021 An IDLE request SHALL be legal only if all four conditions hold: size is not 11; a halfword access has addr[0]=0; a word access has addr[1:0]=00; and addr[31:ADDR_W+2] is zero.
REQ-022 An illegal request SHALL perform no write and leave rdata unchanged.
REQ-023 An illegal request SHALL pulse addr_err high on the following cycle, with rvalid held at 0.
REQ-024 Memory layout SHALL be little-endian: byte lane k = word bits [8k+7:8k], and k = addr[1:0].
REQ-025 A legal store SHALL update only the addressed lanes of word addr[ADDR_W+1:2] at the edge; the other lanes keep their value.
REQ-026 Store byte enables SHALL be: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and addr[1]*2+1; word -> all four lanes.
REQ-027 A legal load SHALL register the extracted, extended value into rdata at the edge and pulse rvalid for exactly one cycle after it (read latency is 1).
REQ-028 rdata SHALL hold its value until the next legal load.
REQ-029 A load issued on the cycle after a store to the same word SHALL return the post-store data.
REQ-030 Back-to-back loads SHALL be supported at one per cycle, with rvalid staying high continuously.
REQ-031 When TRACE=1, each legal store SHALL print "@<pc>: *<word-aligned byte addr> <= <merged 32-bit word>" in hex; the trace is simulation-only and not synthesised.

Reset
REQ-032 When clr_n=0 at a rising edge, the block SHALL enter CLEAR with cnt=0, rdata=0, rvalid=0 and addr_err=0; busy becomes 1 after that edge.
REQ-033 Holding clr_n low SHALL keep cnt at 0.
REQ-034 A reset asserted mid-clear SHALL restart the clear from word 0.
REQ-035 A reset asserted in the same cycle as a pending load SHALL suppress that load's rvalid pulse.
REQ-036 After power-up, the block SHALL be in CLEAR with cnt=0; the memory is all zero once busy falls.

Verification
REQ-037 Clear timing: pulse clr_n low for 1 cycle -> busy=1 for exactly 1024 cycles (ADDR_W=10); a word load then returns 0x00000000.
REQ-038 Sub-word store/load: store word 0x11223344 to addr 0x8; store byte 0xAB to addr 0xA; word-load 0x8 -> 0x11AB3344; byte load of 0xA with sext=1 -> 0xFFFFFFAB; with sext=0 -> 0x000000AB.
REQ-039 Halfword: store half 0x8001 to addr 0x12; half load with sext=1 -> 0xFFFF8001; word load of 0x10 -> 0x80010000.
REQ-040 Errors: word load at 0x6, half store at 0x3, size=11, and addr 0x1000 (ADDR_W=10) -> addr_err pulses, no memory change, rvalid=0.
REQ-041 Busy and reset: a store issued while busy=1 is dropped (a later load reads 0); clr_n low at cycle 500 of a clear -> busy stays high a further 1024 cycles.

Source files
------------

// File: rtl/dm_subword.sv
// Byte-addressable 32-bit data memory with sub-word loads/stores, alignment
// checking and a self-clearing power-up/reset sequence.
module dm_subword #(
    parameter int ADDR_W = 10,
    parameter int TRACE  = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        addr_err,
    output logic        busy
);

    // state | meaning
    // CLEAR | zeroing one word per cycle at index cnt; requests ignored
    // IDLE  | serving load/store requests
    // CLEAR is encoded as 0 so a zero-initialised register powers up clearing.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              hi_ok;
    logic              align_ok;
    logic              legal;
    logic              acc;
    logic              st_ok;
    logic              ld_ok;
    logic              bad;
    logic [3:0]        lane_en;
    logic [31:0]       bmask;
    logic [31:0]       wrep;
    logic [31:0]       cur;
    logic [31:0]       merged;
    logic [31:0]       shifted;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;

    assign busy     = (state == CLEAR);
    assign word_idx = addr[ADDR_W+1:2];
    assign hi_ok    = ((addr >> (ADDR_W + 2)) == 32'd0);
    assign cur      = mem[word_idx];

    always_comb begin
        align_ok = 1'b0;
        case (size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign legal = align_ok & hi_ok;
    assign acc   = (state == IDLE) & req;
    assign st_ok = acc & legal & we;
    assign ld_ok = acc & legal & ~we;
    assign bad   = acc & ~legal;

    always_comb begin
        lane_en = 4'b0000;
        wrep    = wdata;
        case (size)
            2'b00: begin
                lane_en = 4'b0001 << addr[1:0];
                wrep    = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_en = addr[1] ? 4'b1100 : 4'b0011;
                wrep    = {2{wdata[15:0]}};
            end
            2'b10: begin
                lane_en = 4'b1111;
                wrep    = wdata;
            end
            default: begin
                lane_en = 4'b0000;
                wrep    = wdata;
            end
        endcase
    end

    assign bmask  = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
    assign merged = (cur & ~bmask) | (wrep & bmask);

    assign shifted = cur >> {addr[1:0], 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = addr[1] ? cur[31:16] : cur[15:0];

    always_comb begin
        ld_val = cur;
        case (size)
            2'b00:   ld_val = {{24{sext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{sext & ld_half[15]}}, ld_half};
            default: ld_val = cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR: begin
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                state_nx = IDLE;
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (state == CLEAR) begin
                mem[cnt] <= 32'd0;
            end else if (st_ok) begin
                mem[word_idx] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rdata    <= 32'd0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= ld_ok;
            addr_err <= bad;
            if (ld_ok) begin
                rdata <= ld_val;
            end
        end
    end

    generate
        if (TRACE == 1) begin : g_trace
`ifndef SYNTHESIS
            always @(posedge clk) begin
                if (clr_n && st_ok) begin
                    $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dm_subword.sv
// Directed bench for dm_subword: clear timing, sub-word access, errors,
// back-to-back traffic and reset behaviour.
module tb_dm_subword;

    logic        clk;
    logic        clr_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;
    logic        busy;

    int n_cmp;
    int n_bad;

    dm_subword #(.ADDR_W(10), .TRACE(1)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .pc       (pc),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .addr_err (addr_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [1:0] s, input logic sx,
                           input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        size  = s;
        sext  = sx;
        addr  = a;
        wdata = d;
        pc    = pc + 32'd4;
    endtask

    // drive one request through its sampling edge; outputs are then valid
    task automatic issue(input logic w, input logic [1:0] s, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        set_req(w, s, sx, a, d);
        cyc();
        req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        clr_n = 1'b0;
        cyc();
        n_cmp++;
        if (busy !== 1'b1 || rvalid !== 1'b0 || addr_err !== 1'b0 || rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b rvalid=%b addr_err=%b rdata=%h, required 1 0 0 00000000",
                     busy, rvalid, addr_err, rdata);
        end
        clr_n = 1'b1;
        n = 1;
        while (n < 3000) begin
            cyc();
            if (busy) n++;
            else break;
        end
        n_cmp++;
        if (n !== 1024) begin
            n_bad++;
            $display("FAIL clear_cycles: busy for %0d cycles, required 1024", n);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL clear_load: rvalid=%b rdata=%h, required 1 00000000", rvalid, rdata);
        end
        cyc();
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rvalid_pulse: rvalid=%b, required 0", rvalid);
        end
    endtask

    task automatic test_subword();
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB);
        n_cmp++;
        if (rvalid !== 1'b0 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL store_flags: rvalid=%b addr_err=%b, required 0 0", rvalid, addr_err);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h11AB_3344) begin
            n_bad++;
            $display("FAIL word_merge: rvalid=%b rdata=%h, required 1 11ab3344", rvalid, rdata);
        end
        issue(1'b0, 2'b00, 1'b1, 32'hA, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hFFFF_FFAB) begin
            n_bad++;
            $display("FAIL byte_sext: rvalid=%b rdata=%h, required 1 ffffffab", rvalid, rdata);
        end
        issue(1'b0, 2'b00, 1'b0, 32'hA, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_00AB) begin
            n_bad++;
            $display("FAIL byte_zext: rvalid=%b rdata=%h, required 1 000000ab", rvalid, rdata);
        end
        cyc();
        cyc();
        n_cmp++;
        if (rvalid !== 1'b0 || rdata !== 32'h0000_00AB) begin
            n_bad++;
            $display("FAIL rdata_hold: rvalid=%b rdata=%h, required 0 000000ab", rvalid, rdata);
        end
    endtask

    task automatic test_half();
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hFFFF_8001) begin
            n_bad++;
            $display("FAIL half_sext: rvalid=%b rdata=%h, required 1 ffff8001", rvalid, rdata);
        end
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        n_cmp++;
        if (rdata !== 32'h0000_8001) begin
            n_bad++;
            $display("FAIL half_zext: rdata=%h, required 00008001", rdata);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h8001_0000) begin
            n_bad++;
            $display("FAIL half_word: rvalid=%b rdata=%h, required 1 80010000", rvalid, rdata);
        end
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        n_cmp++;
        if (rdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL half_low: rdata=%h, required 00000000", rdata);
        end
    endtask

    task automatic test_errors();
        logic        w   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  s   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] a   [4] = '{32'h6, 32'h3, 32'h8, 32'h1000};
        logic [31:0] d   [4] = '{32'h0, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        for (int i = 0; i < 4; i++) begin
            issue(w[i], s[i], 1'b0, a[i], d[i]);
            n_cmp++;
            if (addr_err !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h0000_0000) begin
                n_bad++;
                $display("FAIL err_%0d: addr_err=%b rvalid=%b rdata=%h, required 1 0 00000000",
                         i, addr_err, rvalid, rdata);
            end
            cyc();
            n_cmp++;
            if (addr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL err_pulse_%0d: addr_err=%b, required 0", i, addr_err);
            end
        end
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL err_word0: rvalid=%b rdata=%h, required 1 00000000", rvalid, rdata);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        n_cmp++;
        if (rdata !== 32'h11AB_3344) begin
            n_bad++;
            $display("FAIL err_word8: rdata=%h, required 11ab3344", rdata);
        end
        issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL top_word: rvalid=%b addr_err=%b, required 1 0", rvalid, addr_err);
        end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_F00D);
        cyc();
        set_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        cyc();
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL st_ld_fwd: rvalid=%b rdata=%h, required 1 cafef00d", rvalid, rdata);
        end
        set_req(1'b1, 2'b00, 1'b0, 32'hD, 32'h0000_0055);
        cyc();
        set_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        cyc();
        n_cmp++;
        if (rdata !== 32'h11AB_3344) begin
            n_bad++;
            $display("FAIL b2b_0: rvalid=%b rdata=%h, required 1 11ab3344", rvalid, rdata);
        end
        set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        cyc();
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h8001_0000) begin
            n_bad++;
            $display("FAIL b2b_1: rvalid=%b rdata=%h, required 1 80010000", rvalid, rdata);
        end
        set_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        cyc();
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hCAFE_550D) begin
            n_bad++;
            $display("FAIL b2b_2: rvalid=%b rdata=%h, required 1 cafe550d", rvalid, rdata);
        end
        req = 1'b0;
        cyc();
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: rvalid=%b, required 0", rvalid);
        end
    endtask

    task automatic test_busy_reset();
        int n;
        int m;
        set_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        clr_n = 1'b0;
        cyc();
        req   = 1'b0;
        clr_n = 1'b1;
        n_cmp++;
        if (rvalid !== 1'b0 || rdata !== 32'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_load: rvalid=%b rdata=%h busy=%b, required 0 00000000 1",
                     rvalid, rdata, busy);
        end
        n = 1;
        while (n < 500) begin
            cyc();
            if (!busy) break;
            n++;
        end
        n_cmp++;
        if (n !== 500) begin
            n_bad++;
            $display("FAIL busy_early: busy fell after %0d cycles, required >= 500", n);
        end
        clr_n = 1'b0;
        cyc();
        clr_n = 1'b1;
        m = 1;
        while (m < 3000) begin
            if (m == 1000) set_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
            else if (m == 1001) set_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
            else if (m == 1002) set_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
            else req = 1'b0;
            cyc();
            if (m == 1002 || m == 1003) begin
                n_cmp++;
                if (rvalid !== 1'b0 || addr_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_ignore_%0d: rvalid=%b addr_err=%b, required 0 0",
                             m, rvalid, addr_err);
                end
            end
            if (busy) m++;
            else break;
        end
        req = 1'b0;
        n_cmp++;
        if (m !== 1024) begin
            n_bad++;
            $display("FAIL restart_cycles: busy for %0d cycles after restart, required 1024", m);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL busy_store_dropped: rvalid=%b rdata=%h, required 1 00000000", rvalid, rdata);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        n_cmp++;
        if (rdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL recleared: rdata=%h, required 00000000", rdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        sext  = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        pc    = 32'h0000_1000;
        test_reset();
        test_subword();
        test_half();
        test_errors();
        test_back_to_back();
        test_busy_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
